timer_requester: RTL and testbench
==================================

# timer_requester

Initiator side of the 5-bit timer request interface: accepts delay commands from a host through a valid/ready port, buffers them in a small FIFO, issues each one to a downstream timer as a one-cycle `in`/`in_valid` pulse, then waits for that timer's `out_valid`. For every command it measures the request-to-completion latency in clock cycles, checks it against the expected value, and returns a status and latency on a valid/ready response port. It sits between test or control logic and a timer instance, and doubles as an in-system checker for the timer.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `TIMEOUT`, 40: cycles to wait for `tmr_out_valid` before declaring timeout (must be > 33).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: host offers a command.
- `cmd_delay` input 5: requested delay N.
- `cmd_ready` output 1: FIFO not full; command accepted when `cmd_valid && cmd_ready`.
- `tmr_in` output 5: delay driven to the timer.
- `tmr_in_valid` output 1: one-cycle request strobe to the timer.
- `tmr_out_valid` input 1: timer completion pulse.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: host consumes response.
- `rsp_status` output 2: 0 OK, 1 MISMATCH, 2 TIMEOUT, 3 ZERO.
- `rsp_latency` output 6: measured cycles from strobe to completion.
- `err_spurious` output 1: sticky; set by `tmr_out_valid` outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, GAP, REPORT.
- IDLE: if FIFO non-empty, pop head into `cur_delay`. If head == 0 → REPORT with status ZERO, latency 0 (never sent to timer; timer does not respond to 0). Else → ISSUE.
- ISSUE (one cycle): `tmr_in_valid`=1, `tmr_in`=`cur_delay`, latency counter cleared to 0 → WAIT.
- WAIT: latency counter increments each cycle (saturates at 63). On `tmr_out_valid`: capture latency L = cycle(out_valid) − cycle(in_valid); status OK if L == N+1, else MISMATCH → GAP. If counter reaches `TIMEOUT` without completion: status TIMEOUT, latency 63 → GAP.
- GAP (one cycle): timer ignores a new strobe in its completion cycle, so no issue allowed here → REPORT.
- REPORT: `rsp_valid`=1, fields held stable until `rsp_ready`; on handshake → IDLE.
- Expected latency rule: strobe with N at cycle t ⇒ timer's `out_valid` at t+N+1 (N=1 → 2, N=31 → 32).
- `tmr_out_valid` in IDLE, ISSUE, GAP or REPORT sets `err_spurious`; does not affect the FSM.
- `tmr_in` holds last issued value when `tmr_in_valid`=0.

## Timing
- Reset: `cmd_ready`=1, `tmr_in`=0, `tmr_in_valid`=0, `rsp_valid`=0, `rsp_status`=0, `rsp_latency`=0, `err_spurious`=0, FSM=IDLE, FIFO empty, counters 0.
- All outputs registered except `cmd_ready` (derived from registered FIFO count).
- Command accepted at cycle c into empty FIFO, FSM idle ⇒ pop at c+1, `tmr_in_valid` at c+2.
- Completion at cycle w ⇒ GAP at w+1, `rsp_valid` at w+2.
- Back-to-back: next strobe no earlier than 2 cycles after response handshake cycle.
- FIFO full: `cmd_ready`=0; simultaneous push and pop when full is allowed (pop frees slot same cycle only if `cmd_ready` is computed from post-pop count — not done: full ⇒ no push).
- Reset mid-WAIT: outstanding command and FIFO contents discarded; later timer pulse sets `err_spurious`.

## Structure
- Package `timer_pkg`: `DELAY_W`=5, `LAT_W`=6, status enum `rsp_status_e`, FSM enum `req_state_e`.
- Sub-module `sync_fifo` (parameterised width/depth, count-based full/empty) for the command queue; FSM, latency counter and response registers in the top.

## Test plan
- Send N=5, `rsp_ready`=1, compliant timer model → strobe with `tmr_in`=5, response OK, latency 6.
- Send N=0 → no strobe, response ZERO, latency 0.
- Model responds at N+3 for N=4 → MISMATCH, latency 7; model never responds → TIMEOUT after 40 cycles, latency 63.
- Push 5 commands (1,31,2,3,4) with `rsp_ready`=0 → `cmd_ready` drops after 4 accepted plus one popped; release → responses in order, latencies 2,32,3,4,5, each strobe ≥2 cycles after previous handshake.
- Pulse `tmr_out_valid` in IDLE → `err_spurious`=1 and stays; assert `rst` during WAIT → all outputs at reset values next cycle, FIFO empty.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared widths, response codes and requester FSM states for the timer request path.
package timer_pkg;

    localparam int DELAY_W = 5;
    localparam int LAT_W   = 6;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_MISMATCH = 2'd1,
        RSP_TIMEOUT  = 2'd2,
        RSP_ZERO     = 2'd3
    } rsp_status_e;

    typedef enum logic [2:0] {
        REQ_IDLE,
        REQ_ISSUE,
        REQ_WAIT,
        REQ_GAP,
        REQ_REPORT
    } req_state_e;

    // A compliant timer answers a strobe carrying N exactly N+1 cycles later.
    function automatic logic [LAT_W-1:0] expected_latency(input logic [DELAY_W-1:0] delay);
        return LAT_W'(delay) + LAT_W'(1);
    endfunction

endpackage

// File: rtl/timer_requester_if.sv
// Host command/response port plus the timer request/completion wires of the requester.
interface timer_requester_if;

    logic                          cmd_valid;
    logic [timer_pkg::DELAY_W-1:0] cmd_delay;
    logic                          cmd_ready;
    logic [timer_pkg::DELAY_W-1:0] tmr_in;
    logic                          tmr_in_valid;
    logic                          tmr_out_valid;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [1:0]                    rsp_status;
    logic [timer_pkg::LAT_W-1:0]   rsp_latency;
    logic                          err_spurious;

    modport master (
        input  cmd_valid, cmd_delay, tmr_out_valid, rsp_ready,
        output cmd_ready, tmr_in, tmr_in_valid, rsp_valid, rsp_status, rsp_latency, err_spurious
    );

    modport slave (
        output cmd_valid, cmd_delay, tmr_out_valid, rsp_ready,
        input  cmd_ready, tmr_in, tmr_in_valid, rsp_valid, rsp_status, rsp_latency, err_spurious
    );

endinterface

// File: rtl/timer_requester_fifo.sv
// Count-based synchronous FIFO; the head entry is visible on dout while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/timer_requester.sv
// Queues host delay commands, issues them to a timer one at a time and reports measured latency.
module timer_requester
    import timer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               rst,
    timer_requester_if.master  bus
);

    localparam logic [LAT_W-1:0] TIMEOUT_CNT = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_MAX     = {LAT_W{1'b1}};

    req_state_e         state;
    req_state_e         state_next;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DELAY_W-1:0] fifo_dout;
    logic [DELAY_W-1:0] cur_delay;
    logic [DELAY_W-1:0] tmr_in_q;
    logic               tmr_in_valid_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               rsp_valid_q;
    rsp_status_e        rsp_status_q;
    logic [LAT_W-1:0]   rsp_latency_q;
    logic               err_spurious_q;
    logic               start_issue;
    logic               take_zero;
    logic               take_done;
    logic               take_timeout;
    logic               rsp_set;
    logic               rsp_clr;

    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign bus.cmd_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (DELAY_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.cmd_delay),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero-delay commands skip the timer entirely since it never answers them.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        start_issue  = 1'b0;
        take_zero    = 1'b0;
        take_done    = 1'b0;
        take_timeout = 1'b0;
        rsp_set      = 1'b0;
        rsp_clr      = 1'b0;
        case (state)
            REQ_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_dout == '0) begin
                        take_zero  = 1'b1;
                        rsp_set    = 1'b1;
                        state_next = REQ_REPORT;
                    end else begin
                        start_issue = 1'b1;
                        state_next  = REQ_ISSUE;
                    end
                end
            end
            REQ_ISSUE: state_next = REQ_WAIT;
            REQ_WAIT: begin
                if (bus.tmr_out_valid) begin
                    take_done  = 1'b1;
                    state_next = REQ_GAP;
                end else if (lat_cnt >= TIMEOUT_CNT) begin
                    take_timeout = 1'b1;
                    state_next   = REQ_GAP;
                end
            end
            REQ_GAP: begin
                rsp_set    = 1'b1;
                state_next = REQ_REPORT;
            end
            REQ_REPORT: begin
                if (bus.rsp_ready) begin
                    rsp_clr    = 1'b1;
                    state_next = REQ_IDLE;
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    // The counter reads 0 in the strobe cycle, so at completion it equals the cycle distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_delay      <= '0;
            tmr_in_q       <= '0;
            tmr_in_valid_q <= 1'b0;
            lat_cnt        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= RSP_OK;
            rsp_latency_q  <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            tmr_in_valid_q <= start_issue;
            if (fifo_pop) begin
                cur_delay <= fifo_dout;
            end
            if (start_issue) begin
                tmr_in_q <= fifo_dout;
                lat_cnt  <= '0;
            end else if ((state == REQ_ISSUE || state == REQ_WAIT) && lat_cnt != LAT_MAX) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            if (take_zero) begin
                rsp_status_q  <= RSP_ZERO;
                rsp_latency_q <= '0;
            end else if (take_done) begin
                rsp_status_q  <= (lat_cnt == expected_latency(cur_delay)) ? RSP_OK : RSP_MISMATCH;
                rsp_latency_q <= lat_cnt;
            end else if (take_timeout) begin
                rsp_status_q  <= RSP_TIMEOUT;
                rsp_latency_q <= LAT_MAX;
            end
            if (rsp_set) begin
                rsp_valid_q <= 1'b1;
            end else if (rsp_clr) begin
                rsp_valid_q <= 1'b0;
            end
            if (bus.tmr_out_valid && state != REQ_WAIT) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

    assign bus.tmr_in       = tmr_in_q;
    assign bus.tmr_in_valid = tmr_in_valid_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_status   = rsp_status_q;
    assign bus.rsp_latency  = rsp_latency_q;
    assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_timer_requester.sv
// Drives delay commands into timer_requester and checks it against a timer model and scoreboard.
module tb_timer_requester;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    timer_requester_if bus ();

    timer_requester #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Command log written by the stimulus side, read by the monitor through its own indices.
    int cmd_log_delay [256];
    int cmd_log_mode  [256];
    int cmd_wr = 0;
    int mode_extra = 0;
    int spur_cnt = 0;

    int exp_rd = 0;
    int iss_rd = 0;
    int spur_seen = 0;
    int hs_count = 0;
    int strobe_count = 0;
    int last_status = -1;
    int last_lat = -1;
    int last_strobe_val = -1;
    int last_issued = 0;
    int last_hs = -100;
    int strobe_cyc = 0;
    int fire_at = 0;
    int cur_extra = 0;
    int exp_rise = -1;
    bit outstanding = 1'b0;
    bit pending = 1'b0;
    bit exp_spur = 1'b0;
    bit prev_rsp_valid = 1'b0;
    int lat_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_status(input int d, input int m);
        if (d == 0) return 3;
        if (m < 0) return 2;
        return (m == 0) ? 0 : 1;
    endfunction

    function automatic int exp_latency(input int d, input int m);
        if (d == 0) return 0;
        if (m < 0) return 63;
        return d + 1 + m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one command until accepted; mode_extra fixes how the timer model answers it.
    task automatic applyStimulus(input int delay);
        bit acc = 1'b0;
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_delay = 5'(delay);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            n++;
        end
        checkOutput("cmd_accept", int'(acc), 1);
        if (acc) begin
            cmd_log_delay[cmd_wr] = delay;
            cmd_log_mode[cmd_wr]  = mode_extra;
            cmd_wr++;
        end
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitResponses(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("rsp_count", hs_count, target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
        checkOutput({tag, "_tmr_in"}, int'(bus.tmr_in), 0);
        checkOutput({tag, "_tmr_in_valid"}, int'(bus.tmr_in_valid), 0);
        checkOutput({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        checkOutput({tag, "_rsp_status"}, int'(bus.rsp_status), 0);
        checkOutput({tag, "_rsp_latency"}, int'(bus.rsp_latency), 0);
        checkOutput({tag, "_err_spurious"}, int'(bus.err_spurious), 0);
    endtask

    // Compare process plus timer model: checks outputs, then drives this cycle's completion pulse.
    always @(negedge clk) begin
        bit pulse;
        bit due;
        if (rst) begin
            exp_rd = cmd_wr;
            iss_rd = cmd_wr;
            outstanding = 1'b0;
            exp_spur = 1'b0;
            exp_rise = -1;
            last_issued = 0;
            prev_rsp_valid = 1'b0;
        end else begin
            checkOutput("err_spurious", int'(bus.err_spurious), int'(exp_spur));
            if (bus.tmr_in_valid) begin
                strobe_count++;
                while (iss_rd < cmd_wr && cmd_log_delay[iss_rd] == 0) iss_rd++;
                if (iss_rd < cmd_wr) begin
                    checkOutput("tmr_in", int'(bus.tmr_in), cmd_log_delay[iss_rd]);
                    checkOutput("strobe_after_handshake", int'(cyc - last_hs >= 2), 1);
                    last_issued = cmd_log_delay[iss_rd];
                    last_strobe_val = int'(bus.tmr_in);
                    cur_extra = cmd_log_mode[iss_rd];
                    outstanding = 1'b1;
                    strobe_cyc = cyc;
                    if (cur_extra >= 0) begin
                        pending = 1'b1;
                        fire_at = cyc + last_issued + 1 + cur_extra;
                    end
                    iss_rd++;
                end else begin
                    checkOutput("strobe_pending_cmds", cmd_wr - iss_rd, 1);
                end
            end else begin
                checkOutput("tmr_in_hold", int'(bus.tmr_in), last_issued);
            end
            if (outstanding && cur_extra < 0 && cyc == strobe_cyc + TIMEOUT) begin
                outstanding = 1'b0;
                exp_rise = cyc + 2;
            end
            if (bus.rsp_valid) begin
                if (!prev_rsp_valid && exp_rise >= 0) begin
                    checkOutput("rsp_rise_cycle", cyc, exp_rise);
                    exp_rise = -1;
                end
                if (exp_rd < cmd_wr) begin
                    checkOutput("rsp_status", int'(bus.rsp_status),
                                exp_status(cmd_log_delay[exp_rd], cmd_log_mode[exp_rd]));
                    checkOutput("rsp_latency", int'(bus.rsp_latency),
                                exp_latency(cmd_log_delay[exp_rd], cmd_log_mode[exp_rd]));
                    if (bus.rsp_ready) begin
                        hs_count++;
                        last_hs = cyc;
                        last_status = int'(bus.rsp_status);
                        last_lat = int'(bus.rsp_latency);
                        lat_log.push_back(last_lat);
                        exp_rd++;
                    end
                end else begin
                    checkOutput("rsp_pending_cmds", cmd_wr - exp_rd, 1);
                end
            end
            prev_rsp_valid = bus.rsp_valid;
        end
        due = pending && (cyc == fire_at);
        if (due) pending = 1'b0;
        pulse = due || (spur_cnt != spur_seen);
        spur_seen = spur_cnt;
        if (pulse && !rst) begin
            if (outstanding) begin
                outstanding = 1'b0;
                exp_rise = cyc + 2;
            end else begin
                exp_spur = 1'b1;
            end
        end
        bus.tmr_out_valid = pulse;
    end

    initial begin
        int sc;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_delay = '0;
        bus.rsp_ready = 1'b1;
        bus.tmr_out_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);

        $display("[TB] compliant timer, N=5");
        mode_extra = 0;
        applyStimulus(5);
        waitResponses(1, 60);
        checkOutput("n5_tmr_in", last_strobe_val, 5);
        checkOutput("n5_status", last_status, 0);
        checkOutput("n5_latency", last_lat, 6);

        $display("[TB] zero delay");
        sc = strobe_count;
        applyStimulus(0);
        waitResponses(2, 20);
        checkOutput("n0_status", last_status, 3);
        checkOutput("n0_latency", last_lat, 0);
        checkOutput("n0_no_strobe", strobe_count, sc);

        $display("[TB] late timer, N=4");
        mode_extra = 2;
        applyStimulus(4);
        waitResponses(3, 60);
        checkOutput("late_status", last_status, 1);
        checkOutput("late_latency", last_lat, 7);

        $display("[TB] silent timer, N=7");
        mode_extra = -1;
        applyStimulus(7);
        waitResponses(4, 80);
        checkOutput("silent_status", last_status, 2);
        checkOutput("silent_latency", last_lat, 63);

        $display("[TB] fill command queue with responses held");
        mode_extra = 0;
        cycles(3);
        bus.rsp_ready = 1'b0;
        applyStimulus(1);
        applyStimulus(31);
        applyStimulus(2);
        applyStimulus(3);
        applyStimulus(4);
        @(negedge clk);
        checkOutput("fifo_full_ready", int'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_delay = 5'd9;
        cycles(1);
        bus.cmd_valid = 1'b0;
        cycles(10);
        bus.rsp_ready = 1'b1;
        waitResponses(9, 300);
        if (lat_log.size() >= 9) begin
            checkOutput("queue_lat0", lat_log[4], 2);
            checkOutput("queue_lat1", lat_log[5], 32);
            checkOutput("queue_lat2", lat_log[6], 3);
            checkOutput("queue_lat3", lat_log[7], 4);
            checkOutput("queue_lat4", lat_log[8], 5);
        end else begin
            checkOutput("queue_log_size", lat_log.size(), 9);
        end

        $display("[TB] stray completion pulse while idle");
        cycles(3);
        spur_cnt++;
        cycles(3);
        checkOutput("spur_idle_set", int'(bus.err_spurious), 1);
        cycles(5);
        checkOutput("spur_idle_sticky", int'(bus.err_spurious), 1);

        $display("[TB] reset during wait");
        applyStimulus(20);
        applyStimulus(3);
        sc = strobe_count;
        n = 0;
        while (strobe_count == sc && n < 20) begin
            @(posedge clk);
            n++;
        end
        checkOutput("mid_wait_strobe_seen", strobe_count, sc + 1);
        cycles(5);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(2);
        checkOutput("post_reset_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("post_reset_cmd_ready", int'(bus.cmd_ready), 1);
        cycles(25);
        checkOutput("stale_pulse_spurious", int'(bus.err_spurious), 1);
        checkOutput("no_strobe_after_reset", strobe_count, sc + 1);
        checkOutput("no_rsp_after_reset", int'(bus.rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
